// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access; grants are combinational, read data returns 1 cycle after grant.
// Data wins by default, but a pending fetch is forced through after MAX_DSTREAK back-to-back data grants; losers simply hold their request.
module mem_port_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int MAX_DSTREAK = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DRD  = 2'd2
    } own_t;

    localparam logic [3:0] DSTREAK_MAX = 4'(MAX_DSTREAK);

    own_t       resp_own;
    own_t       resp_own_nxt;
    logic [3:0] dstreak;
    logic [3:0] dstreak_nxt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            resp_own <= OWN_NONE;
            dstreak  <= 4'd0;
        end else begin
            resp_own <= resp_own_nxt;
            dstreak  <= dstreak_nxt;
        end
    end

    always_comb begin
        if_gnt       = 1'b0;
        d_gnt        = 1'b0;
        resp_own_nxt = OWN_NONE;
        dstreak_nxt  = dstreak;

        if (reset) begin
            if (if_req && (!d_req || dstreak == DSTREAK_MAX)) begin
                if_gnt = 1'b1;
            end else if (d_req) begin
                d_gnt = 1'b1;
            end
        end

        if (if_gnt) begin
            resp_own_nxt = OWN_IF;
        end else if (d_gnt && !d_we) begin
            resp_own_nxt = OWN_DRD;
        end

        // The streak only measures starvation of a waiting fetch.
        if (if_gnt || !if_req) begin
            dstreak_nxt = 4'd0;
        end else if (d_gnt && dstreak != DSTREAK_MAX) begin
            dstreak_nxt = dstreak + 4'd1;
        end
    end

    always_comb begin
        mem_en    = if_gnt | d_gnt;
        mem_we    = d_gnt & d_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (if_gnt) begin
            mem_addr = if_addr;
        end else if (d_gnt) begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end
    end

    // Gating with reset drops a response whose grant preceded a reset cycle.
    assign if_rvalid = reset && (resp_own == OWN_IF);
    assign d_rvalid  = reset && (resp_own == OWN_DRD);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign d_rdata   = d_rvalid  ? mem_rdata : '0;

endmodule
